// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the seven-segment bus snooper.
// Segment codes are active-low {g,f,e,d,c,b,a}.
package seg_scan_pkg;

  typedef enum logic [1:0] {
    WAIT_SEL,
    SETTLE,
    LATCHED
  } state_t;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seven;
  } sample_t;

  localparam logic [6:0] BLANK_SEG = 7'h7F;

  localparam logic [15:0][6:0] SEG_TAB = {
    7'h0E, 7'h06, 7'h21, 7'h46,
    7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19,
    7'h30, 7'h24, 7'h79, 7'h40
  };

  localparam sample_t IDLE_SAMPLE = '{
    an: 4'hF,
    seven: BLANK_SEG
  };

  function automatic logic one_hot_low(
    input logic [3:0] an
  );
    return $onehot(~an);
  endfunction

endpackage

// File: rtl/seg_to_nibble.sv
// Reverse lookup of an active-low segment code into a hex nibble.
// hit is low when the code is not one of the sixteen table glyphs.
module seg_to_nibble
  import seg_scan_pkg::*;
(
  input  logic [6:0] seven,
  output logic       hit,
  output logic [3:0] nibble
);

  // Scan the table; codes are unique so at most one entry matches.
  always_comb begin
    hit = 1'b0;
    nibble = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (seven == SEG_TAB[i]) begin
        hit = 1'b1;
        nibble = 4'(i);
      end
    end
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Snoops a multiplexed 4-digit seven-segment bus and rebuilds the hex word.
// Define SEG_SCAN_DECODE_ERR_EN to reject unknown glyphs and raise err.
module seg_scan_decoder
  import seg_scan_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int SYNC_STAGES   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  seven,
  input  logic [3:0]  an,
  output logic [15:0] value,
  output logic        value_valid,
  output logic [3:0]  digit_mask,
  output logic        err
);

  localparam logic [7:0] STABLE_N = 8'(STABLE_CYCLES);

  logic [SYNC_STAGES-1:0][6:0] seven_sync;
  logic [SYNC_STAGES-1:0][3:0] an_sync;

  sample_t cur;
  sample_t samp;
  sample_t samp_n;

  state_t state;
  state_t state_n;

  logic [7:0] cnt;
  logic [7:0] cnt_n;
  logic [7:0] cnt_inc;

  logic sel;
  logic same;
  logic enter;
  logic cap;
  logic wr;

  logic       hit;
  logic [3:0] nib;
  logic [3:0] dig;
  logic [3:0] mask_add;

  logic [3:0][3:0] slots;
  logic [3:0][3:0] slots_n;

  // Bring the asynchronous bus into the clock domain; idle is all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      seven_sync <= '1;
      an_sync <= '1;
    end else begin
      seven_sync[0] <= seven;
      an_sync[0] <= an;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        seven_sync[i] <= seven_sync[i-1];
        an_sync[i] <= an_sync[i-1];
      end
    end
  end

  assign cur.an = an_sync[SYNC_STAGES-1];
  assign cur.seven = seven_sync[SYNC_STAGES-1];

  assign sel = one_hot_low(cur.an);
  assign same = (cur == samp);
  assign cnt_inc = cnt + 8'd1;

  seg_to_nibble u_dec (
    .seven (cur.seven),
    .hit   (hit),
    .nibble(nib)
  );

  // Next-state logic: a digit is accepted once its sample has held
  // unchanged for STABLE_CYCLES synced cycles.
  always_comb begin
    state_n = state;
    samp_n = samp;
    cnt_n = cnt;
    cap = 1'b0;
    enter = 1'b0;
    unique case (state)
      WAIT_SEL: begin
        enter = 1'b1;
      end
      SETTLE: begin
        if (same) begin
          cnt_n = cnt_inc;
          if (cnt_inc == STABLE_N) begin
            cap = 1'b1;
            state_n = LATCHED;
          end
        end else if (sel) begin
          samp_n = cur;
          cnt_n = 8'd1;
        end else begin
          state_n = WAIT_SEL;
        end
      end
      LATCHED: begin
        if (!same) begin
          enter = 1'b1;
        end
      end
      default: begin
        state_n = WAIT_SEL;
      end
    endcase
    // Leaving LATCHED reuses the selection check so a direct
    // digit-to-digit change starts settling without a gap.
    if (enter) begin
      if (sel) begin
        samp_n = cur;
        cnt_n = 8'd1;
        if (STABLE_N == 8'd1) begin
          cap = 1'b1;
          state_n = LATCHED;
        end else begin
          state_n = SETTLE;
        end
      end else begin
        state_n = WAIT_SEL;
      end
    end
  end

  assign dig = ~cur.an;

`ifdef SEG_SCAN_DECODE_ERR_EN
  assign wr = cap & hit;
`else
  assign wr = cap;
`endif

  assign mask_add = digit_mask | dig;

  // Merge the decoded nibble into its slot.
  always_comb begin
    slots_n = slots;
    for (int i = 0; i < 4; i++) begin
      if (dig[i]) begin
        slots_n[i] = nib;
      end
    end
  end

  // Capture FSM state, counter and sample register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= WAIT_SEL;
      samp <= IDLE_SAMPLE;
      cnt <= 8'd0;
    end else begin
      state <= state_n;
      samp <= samp_n;
      cnt <= cnt_n;
    end
  end

  // Frame assembly: publish the word once all four digits are seen.
  always_ff @(posedge clk) begin
    if (rst) begin
      slots <= '0;
      digit_mask <= 4'h0;
      value <= 16'h0000;
      value_valid <= 1'b0;
    end else begin
      value_valid <= 1'b0;
      if (wr) begin
        slots <= slots_n;
        if (mask_add == 4'hF) begin
          value <= slots_n;
          value_valid <= 1'b1;
          digit_mask <= 4'h0;
        end else begin
          digit_mask <= mask_add;
        end
      end
    end
  end

`ifdef SEG_SCAN_DECODE_ERR_EN
  // Sticky flag for glyphs outside the hex table.
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (cap && !hit) begin
      err <= 1'b1;
    end
  end
`else
  logic unused_hit;
  assign unused_hit = hit;
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder with a run-length reference model.
// Expectations for err follow SEG_SCAN_DECODE_ERR_EN.
module tb_seg_scan_decoder;

  localparam int SYNC = 2;
  localparam int STABLE = 4;

`ifdef SEG_SCAN_DECODE_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  seven = 7'h7F;
  logic [3:0]  an = 4'hF;
  logic [15:0] value;
  logic        value_valid;
  logic [3:0]  digit_mask;
  logic        err;

  seg_scan_decoder #(
    .STABLE_CYCLES(STABLE),
    .SYNC_STAGES  (SYNC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .seven      (seven),
    .an         (an),
    .value      (value),
    .value_valid(value_valid),
    .digit_mask (digit_mask),
    .err        (err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Hex glyph table, active-low {g..a}.
  logic [6:0] tab [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Reference model: a digit is captured on the cycle its synced
  // one-hot sample has been seen for exactly STABLE consecutive cycles.
  bit          started = 1'b0;
  logic [10:0] q[$];
  logic [10:0] prev;
  int          run;
  logic [15:0] m_value;
  logic        m_valid;
  logic [3:0]  m_mask;
  logic        m_err;
  logic [3:0]  m_slot [4];

  always @(posedge clk) begin
    logic [10:0] s;
    int zeros;
    int idx;
    bit hit;
    logic [3:0] nib;
    if (rst) begin
      started = 1'b1;
      q = {};
      for (int i = 0; i < SYNC; i++) q.push_back(11'h7FF);
      prev = 11'h7FF;
      run = 0;
      m_value = 16'h0;
      m_valid = 1'b0;
      m_mask = 4'h0;
      m_err = 1'b0;
      for (int i = 0; i < 4; i++) m_slot[i] = 4'h0;
    end else if (started) begin
      q.push_back({an, seven});
      s = q.pop_front();
      run = (s == prev) ? run + 1 : 1;
      prev = s;
      m_valid = 1'b0;
      zeros = 0;
      idx = 0;
      for (int i = 0; i < 4; i++) begin
        if (!s[7+i]) begin
          zeros++;
          idx = i;
        end
      end
      if (zeros == 1 && run == STABLE) begin
        hit = 1'b0;
        nib = 4'h0;
        for (int k = 0; k < 16; k++) begin
          if (tab[k] == s[6:0]) begin
            hit = 1'b1;
            nib = 4'(k);
          end
        end
        if (!hit && ERR_EN) begin
          m_err = 1'b1;
        end else begin
          m_slot[idx] = nib;
          m_mask[idx] = 1'b1;
          if (m_mask == 4'hF) begin
            m_value = {m_slot[3], m_slot[2], m_slot[1], m_slot[0]};
            m_valid = 1'b1;
            m_mask = 4'h0;
          end
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (started) begin
      chk("value", 32'(value), 32'(m_value));
      chk("value_valid", 32'(value_valid), 32'(m_valid));
      chk("digit_mask", 32'(digit_mask), 32'(m_mask));
      chk("err", 32'(err), 32'(m_err));
    end
  end

  // Observation of pulses, mask steps and first digit-0 capture.
  int         cyc = 0;
  int         pulses = 0;
  int         cap0 = -1;
  int         last_chg = 0;
  logic [3:0] prev_mask = 4'h0;
  logic [3:0] trace[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (started) begin
      if (value_valid) pulses++;
      if (digit_mask[0] && !prev_mask[0] && cap0 < 0) cap0 = cyc;
      if (digit_mask != prev_mask) trace.push_back(digit_mask);
      prev_mask = digit_mask;
    end
  end

  task automatic drive(input logic [3:0] a, input logic [6:0] s,
                       input int n);
    @(negedge clk);
    an = a;
    seven = s;
    last_chg = cyc;
    repeat (n) @(posedge clk);
  endtask

  task automatic idle(input int n);
    drive(4'hF, 7'h7F, n);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    an = 4'hF;
    seven = 7'h7F;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    trace = {};
    pulses = 0;
    cap0 = -1;
  endtask

  task automatic chk_trace(input string name, input logic [3:0] e0,
                           input logic [3:0] e1, input logic [3:0] e2,
                           input logic [3:0] e3);
    logic [3:0] e [4];
    e = '{e0, e1, e2, e3};
    chk({name, "_len"}, 32'(trace.size()), 32'd4);
    for (int i = 0; i < 4 && i < trace.size(); i++)
      chk({name, "_step"}, 32'(trace[i]), 32'(e[i]));
  endtask

  initial begin
    int t0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Idle bus.
    idle(50);
    #1;
    chk("idle_value", 32'(value), 32'h0);
    chk("idle_pulses", 32'(pulses), 32'd0);
    chk("idle_mask", 32'(digit_mask), 32'h0);
    chk("idle_err", 32'(err), 32'h0);

    // Basic scan 0..3.
    apply_reset();
    drive(4'hE, 7'h24, 8);
    drive(4'hD, 7'h30, 8);
    drive(4'hB, 7'h19, 8);
    drive(4'h7, 7'h12, 8);
    idle(10);
    #1;
    chk("scan_pulses", 32'(pulses), 32'd1);
    chk("scan_value", 32'(value), 32'h5432);
    chk_trace("scan_mask", 4'h1, 4'h3, 4'h7, 4'h0);

    // Too short to settle.
    apply_reset();
    drive(4'hE, 7'h40, 3);
    drive(4'hD, 7'h79, 3);
    drive(4'hB, 7'h24, 3);
    drive(4'h7, 7'h30, 3);
    idle(10);
    #1;
    chk("short_trace_len", 32'(trace.size()), 32'd0);
    chk("short_mask", 32'(digit_mask), 32'h0);
    chk("short_pulses", 32'(pulses), 32'd0);

    // Just long enough; measure latency.
    apply_reset();
    drive(4'hE, 7'h40, 4);
    t0 = last_chg;
    drive(4'hD, 7'h79, 4);
    drive(4'hB, 7'h24, 4);
    drive(4'h7, 7'h30, 4);
    idle(10);
    #1;
    chk("lat_seen", 32'(cap0 >= 0), 32'd1);
    chk("lat_cycles", 32'(cap0 - t0), 32'(SYNC + STABLE));
    chk("hold4_pulses", 32'(pulses), 32'd1);
    chk("hold4_value", 32'(value), 32'h3210);

    // Out-of-order scan with a recapture.
    apply_reset();
    drive(4'h7, 7'h46, 8);
    drive(4'hD, 7'h79, 8);
    drive(4'hE, 7'h40, 8);
    drive(4'hD, 7'h08, 8);
    drive(4'hB, 7'h0E, 8);
    idle(10);
    #1;
    chk("order_pulses", 32'(pulses), 32'd1);
    chk("order_value", 32'(value), 32'hCFA0);
    chk_trace("order_mask", 4'h8, 4'hA, 4'hB, 4'h0);

    // Blank glyph mid-frame.
    apply_reset();
    drive(4'hE, 7'h40, 8);
    drive(4'hD, 7'h7F, 8);
    #1;
    chk("blank_err", 32'(err), 32'(ERR_EN));
    chk("blank_mask1", 32'(digit_mask[1]), 32'(!ERR_EN));
    drive(4'hD, 7'h79, 8);
    drive(4'hB, 7'h24, 8);
    drive(4'h7, 7'h30, 8);
    idle(10);
    #1;
    chk("blank_err_sticky", 32'(err), 32'(ERR_EN));
    chk("blank_value", 32'(value), 32'h3210);
    chk("blank_pulses", 32'(pulses), 32'd1);

    // Reset mid-frame.
    drive(4'hE, 7'h19, 8);
    drive(4'hD, 7'h12, 8);
    drive(4'hB, 7'h02, 8);
    #1;
    chk("mid_mask", 32'(digit_mask), 32'h7);
    @(negedge clk);
    rst = 1'b1;
    an = 4'hF;
    seven = 7'h7F;
    @(posedge clk);
    #1;
    chk("rst_mask", 32'(digit_mask), 32'h0);
    chk("rst_value", 32'(value), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    trace = {};
    pulses = 0;
    drive(4'hE, 7'h19, 8);
    drive(4'hD, 7'h12, 8);
    drive(4'hB, 7'h02, 8);
    drive(4'h7, 7'h78, 8);
    idle(10);
    #1;
    chk("rescan_pulses", 32'(pulses), 32'd1);
    chk("rescan_value", 32'(value), 32'h7654);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
- Receive-side counterpart of the binary-to-seven-segment encoder path.
- Snoops a multiplexed 4-digit seven-segment bus (active-low segments plus active-low anodes) and reconstructs the 16-bit hex word being displayed.
- Used for loopback self-check of the display driver, and to read displays from another board.
- Sequential: input synchronisation, per-digit stability filter, capture FSM, frame assembly.

Parameters:
- STABLE_CYCLES, 4: consecutive identical synced samples (anode plus segments) required before a digit is accepted; legal range 1..255.
- SYNC_STAGES, 2: synchroniser depth on seven/an; legal range 2..3.

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- seven  in  7  segment lines {g,f,e,d,c,b,a}, active-low
- an  in  4  digit anodes, active-low; an[i] low selects digit i
- value  out  16  last complete frame; digit i occupies value[4i+3:4i]
- value_valid  out  1  one-cycle pulse when value updates
- digit_mask  out  4  digits captured in the current frame
- err  out  1  sticky invalid-pattern flag (see Optional Feature)

Behaviour:
- Reset, synchronous, active-high:
  - value = 16'h0000, value_valid = 0, digit_mask = 4'h0, err = 0.
  - Synchroniser flops cleared to all-ones (bus idle).
  - FSM enters WAIT_SEL; stability counter = 0.
  - Reset asserted mid-frame discards all partial nibbles.
- Input path: seven and an each pass through SYNC_STAGES flops; all decisions use synced values.
- FSM WAIT_SEL:
  - Stay while synced an is not one-hot-low (4'hF, or two or more lows).
  - On one-hot-low: load sample register {an, seven}, counter = 1, go to SETTLE.
  - If STABLE_CYCLES == 1, go straight to the capture action.
- FSM SETTLE:
  - Each cycle, compare the synced sample to the sample register.
  - Equal: counter increments. When the counter reaches STABLE_CYCLES, perform capture on that edge and go to LATCHED.
  - Not equal, still one-hot: reload the sample register, counter = 1.
  - Not equal, not one-hot: go to WAIT_SEL.
- Capture action:
  - Decode seven to a nibble using the shared table.
  - Write the nibble to the digit slot and set digit_mask[i].
  - Recapturing a digit already in the mask overwrites its nibble; the mask is unchanged.
- Frame completion:
  - When a capture makes the mask 4'hF, value is loaded from all four slots, value_valid = 1 for exactly that cycle, and digit_mask clears to 0 on the same edge.
  - Digit capture order is irrelevant.
- FSM LATCHED:
  - Hold until the synced sample differs from the sample register, then go to WAIT_SEL.
  - That same cycle is evaluated as in WAIT_SEL, so a direct digit-to-digit change enters SETTLE with no gap.
  - A pattern that never changes yields one capture only.
- Latency: pin change to capture = SYNC_STAGES + STABLE_CYCLES clocks.
- Blank digit (seven = 7'h7F) is treated as an invalid pattern.

Optional Feature:
- Macro: SEG_SCAN_DECODE_ERR_EN.
- Defined:
  - A pattern not in the 16-entry table is not captured: no mask bit set, no nibble write.
  - err sets and stays set until rst.
  - FSM still goes to LATCHED.
- Undefined:
  - An unknown pattern decodes to 4'h0 and is captured normally.
  - err is tied to 0.

Decomposition:
- Package seg_scan_pkg holds:
  - the active-low segment table for 0..F: 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E (hex);
  - the FSM state enum {WAIT_SEL, SETTLE, LATCHED};
  - BLANK_SEG = 7'h7F.
- Sub-module seg_to_nibble: combinational seven -> {hit, nibble[3:0]}, the table reverse lookup. One instance.

Test Plan:
- Reset, then idle bus (an = F, seven = 7F) for 50 cycles -> value = 0000, value_valid never asserted, digit_mask = 0, err = 0.
- Scan digits 0..3 with 24, 30, 19, 12 (each digit held 8 clocks, STABLE_CYCLES = 4) -> one value_valid pulse with value = 5432. Mask steps 1, 3, 7, then 0 on the pulse cycle.
- Each digit held only 3 synced cycles with STABLE_CYCLES = 4 -> no capture, digit_mask stays 0. Increase hold to 4 -> capture occurs exactly SYNC_STAGES + 4 clocks after the pin change.
- Scan order 3, 1, 0, 1 (recapture 08), then 2, with patterns 3 = 46, 1 = 79 then 08, 0 = 40, 2 = 0E -> value = CFA0, single pulse after digit 2.
- Macro defined: digit 1 shows 7F mid-frame -> err = 1 and sticky; mask bit 1 stays clear. Valid 79 afterwards completes the frame with nibble 1. Macro undefined: same stimulus leaves err = 0 and captures 0.
- Assert rst with mask = 4'h7 mid-frame -> next cycle mask = 0, value = 0000. A fresh full scan then yields one correct pulse.
